// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Power-switch enable sequencer: staggered thermometer ramp of NSEG header segments, ACK handshake,
// sticky fault. Define GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN to add the ISO isolation-clamp output.
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(
    parameter int NSEG     = 8,
    parameter int STEP_CYC = 4,
    parameter int ACK_TO   = 16
) (
    input  logic            CLK,
    input  logic            RN,
    input  logic            REQ,
    input  logic            ACK_IN,
    output logic [NSEG-1:0] EN,
    output logic            PWR_GOOD,
    output logic            BUSY,
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
    output logic            ISO,
`endif
    output logic            ERR
);

    localparam int SW = $clog2(STEP_CYC + 1);
    localparam int TW = $clog2(ACK_TO + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TO - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(ACK_TO);

    typedef enum logic [2:0] {
        S_OFF, S_RAMP_UP, S_WAIT_ACK, S_ON, S_RAMP_DN, S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [NSEG-1:0] en_nxt, en_up, en_dn;
    logic            pg_nxt, busy_nxt, err_nxt;
    logic [SW-1:0]   step_cnt, step_nxt, step_inc;
    logic [TW-1:0]   to_cnt, to_nxt, to_inc;
    logic            ack_m, ack_s;
    logic            step_due, dn_entry, fault;

    // ACK_IN comes from the far end of the switch chain with no clock relationship.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ACK_IN;
            ack_s <= ack_m;
        end
    end

    assign en_up    = {EN[NSEG-2:0], 1'b1};
    assign en_dn    = {1'b0, EN[NSEG-1:1]};
    assign step_due = (step_cnt == STEP_LAST);
    assign step_inc = step_due ? step_cnt : step_cnt + 1'b1;
    assign to_inc   = (to_cnt == TO_MAX) ? to_cnt : to_cnt + 1'b1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt = state;
        en_nxt    = EN;
        pg_nxt    = PWR_GOOD;
        busy_nxt  = BUSY;
        err_nxt   = ERR;
        step_nxt  = step_cnt;
        to_nxt    = to_cnt;
        dn_entry  = 1'b0;
        fault     = 1'b0;

        case (state)
            S_OFF: begin
                if (REQ) begin
                    state_nxt = S_RAMP_UP;
                    en_nxt    = NSEG'(1);
                    busy_nxt  = 1'b1;
                    err_nxt   = 1'b0;
                    step_nxt  = '0;
                end
            end
            S_RAMP_UP: begin
                if (!REQ) begin
                    dn_entry = 1'b1;
                end else if (step_due) begin
                    en_nxt   = en_up;
                    step_nxt = '0;
                    if (&en_up) begin
                        state_nxt = S_WAIT_ACK;
                        to_nxt    = '0;
                    end
                end else begin
                    step_nxt = step_inc;
                end
            end
            S_WAIT_ACK: begin
                if (!REQ) begin
                    dn_entry = 1'b1;
                end else if (ack_s) begin
                    state_nxt = S_ON;
                    pg_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    fault = 1'b1;
                end else begin
                    to_nxt = to_inc;
                end
            end
            S_ON: begin
                if (!REQ) begin
                    state_nxt = S_RAMP_DN;
                    pg_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
                    // Hold EN for one edge so the clamp closes before the rail starts to sag.
                    step_nxt  = STEP_LAST;
`else
                    en_nxt    = en_dn;
                    step_nxt  = '0;
`endif
                end else if (!ack_s) begin
                    fault = 1'b1;
                end
            end
            S_RAMP_DN: begin
                if (REQ) begin
                    state_nxt = S_RAMP_UP;
                    step_nxt  = '0;
                end else if (step_due) begin
                    en_nxt   = en_dn;
                    step_nxt = '0;
                    if (en_dn == '0) begin
                        state_nxt = S_OFF;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    step_nxt = step_inc;
                end
            end
            S_FAULT: begin
                if (!REQ) state_nxt = S_OFF;
            end
            default: begin
                state_nxt = S_OFF;
                en_nxt    = '0;
                pg_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase

        // Reversing out of a rising ramp clears the top segment on the same edge.
        if (dn_entry) begin
            en_nxt    = en_dn;
            step_nxt  = '0;
            state_nxt = (en_dn == '0) ? S_OFF : S_RAMP_DN;
            busy_nxt  = (en_dn != '0);
        end
        if (fault) begin
            state_nxt = S_FAULT;
            en_nxt    = '0;
            pg_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state    <= S_OFF;
            EN       <= '0;
            PWR_GOOD <= 1'b0;
            BUSY     <= 1'b0;
            ERR      <= 1'b0;
            step_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            EN       <= en_nxt;
            PWR_GOOD <= pg_nxt;
            BUSY     <= busy_nxt;
            ERR      <= err_nxt;
            step_cnt <= step_nxt;
            to_cnt   <= to_nxt;
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
    // Released only after a full cycle in ON; reasserted on the edge that leaves ON.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) ISO <= 1'b1;
        else     ISO <= !((state == S_ON) && (state_nxt == S_ON));
    end
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Scoreboard bench for the power-switch sequencer (NSEG=4, STEP_CYC=2, ACK_TO=8); the driver queues
// hand-computed per-edge expectations and a monitor compares them 1 ns after each rising edge.
module tb_gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq;

    logic       CLK = 1'b0;
    logic       RN, REQ, ACK_IN;
    logic [3:0] EN;
    logic       PWR_GOOD, BUSY, ERR;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
    logic       ISO;
`endif

    typedef struct {
        logic [3:0] en;
        logic       pg;
        logic       busy;
        logic       err;
        logic       iso;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   v_idx = 0;

    gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq #(.NSEG(4), .STEP_CYC(2), .ACK_TO(8)) dut (
        .CLK      (CLK),
        .RN       (RN),
        .REQ      (REQ),
        .ACK_IN   (ACK_IN),
        .EN       (EN),
        .PWR_GOOD (PWR_GOOD),
        .BUSY     (BUSY),
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
        .ISO      (ISO),
`endif
        .ERR      (ERR)
    );

    initial forever #5 CLK = ~CLK;

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: en/pg/busy/err/iso got %b want %b", name, act, want);
        end
    endtask

    function automatic logic [7:0] dut_word();
        logic [7:0] w;
        w = {EN, PWR_GOOD, BUSY, ERR, 1'b0};
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
        w[0] = ISO;
`endif
        return w;
    endfunction

    function automatic logic [7:0] exp_word(input exp_t e);
        logic [7:0] w;
        w = {e.en, e.pg, e.busy, e.err, 1'b0};
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
        w[0] = e.iso;
`endif
        return w;
    endfunction

    // Monitor: one pop per rising edge for which the driver queued an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                compare($sformatf("vec%0d", v_idx), dut_word(), exp_word(e));
                v_idx++;
            end
        end
    end

    // Inputs applied at the falling edge; expectation describes outputs after the next rising edge.
    task automatic vec(input logic rq, input logic ak, input logic [3:0] en,
                       input logic pg, input logic bz, input logic er, input logic io);
        @(negedge CLK);
        REQ    = rq;
        ACK_IN = ak;
        sb.push_back('{en, pg, bz, er, io});
    endtask

    task automatic rep(input int n, input logic rq, input logic ak, input logic [3:0] en,
                       input logic pg, input logic bz, input logic er, input logic io);
        for (int i = 0; i < n; i++) vec(rq, ak, en, pg, bz, er, io);
    endtask

    initial begin
        RN = 1'b0; REQ = 1'b0; ACK_IN = 1'b0;

        // 1: reset, then idle with REQ low
        rep(3, 0, 0, 4'b0000, 0, 0, 0, 1);
        #2 RN = 1'b1;
        rep(20, 0, 0, 4'b0000, 0, 0, 0, 1);

        // 2: full ramp-up, ACK arrives, PWR_GOOD after sync + state cycle, ISO drops one later
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(1, 0, 4'b0111, 0, 1, 0, 1);
        vec(1, 0, 4'b0111, 0, 1, 0, 1);
        vec(1, 0, 4'b1111, 0, 1, 0, 1);
        vec(1, 1, 4'b1111, 0, 1, 0, 1);
        vec(1, 1, 4'b1111, 0, 1, 0, 1);
        vec(1, 1, 4'b1111, 1, 0, 0, 1);
        rep(3, 1, 1, 4'b1111, 1, 0, 0, 0);

        // 3: ramp-down from ON
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSW_ISO_EN
        vec(0, 1, 4'b1111, 0, 1, 0, 1);
        rep(2, 0, 1, 4'b0111, 0, 1, 0, 1);
`else
        rep(2, 0, 1, 4'b0111, 0, 1, 0, 1);
`endif
        rep(2, 0, 1, 4'b0011, 0, 1, 0, 1);
        rep(2, 0, 1, 4'b0001, 0, 1, 0, 1);
        vec(0, 1, 4'b0000, 0, 0, 0, 1);
        rep(2, 0, 0, 4'b0000, 0, 0, 0, 1);

        // 4: abort at 0011, re-request mid ramp-down, abort again
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(0, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(0, 0, 4'b0001, 0, 1, 0, 1);
        vec(0, 0, 4'b0001, 0, 1, 0, 1);
        vec(0, 0, 4'b0000, 0, 0, 0, 1);
        rep(2, 0, 0, 4'b0000, 0, 0, 0, 1);

        // 5: ACK never comes -> timeout after 8 WAIT_ACK cycles, sticky ERR, cleared by restart
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        vec(1, 0, 4'b0111, 0, 1, 0, 1);
        vec(1, 0, 4'b0111, 0, 1, 0, 1);
        vec(1, 0, 4'b1111, 0, 1, 0, 1);
        rep(7, 1, 0, 4'b1111, 0, 1, 0, 1);
        rep(3, 1, 0, 4'b0000, 0, 0, 1, 1);
        rep(2, 0, 0, 4'b0000, 0, 0, 1, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);

        // 6: ACK early, reach ON, lose ACK -> FAULT two edges later
        vec(1, 1, 4'b0001, 0, 1, 0, 1);
        vec(1, 1, 4'b0011, 0, 1, 0, 1);
        vec(1, 1, 4'b0011, 0, 1, 0, 1);
        vec(1, 1, 4'b0111, 0, 1, 0, 1);
        vec(1, 1, 4'b0111, 0, 1, 0, 1);
        vec(1, 1, 4'b1111, 0, 1, 0, 1);
        vec(1, 1, 4'b1111, 1, 0, 0, 1);
        rep(2, 1, 1, 4'b1111, 1, 0, 0, 0);
        rep(2, 1, 0, 4'b1111, 1, 0, 0, 0);
        vec(1, 0, 4'b0000, 0, 0, 1, 1);
        vec(0, 0, 4'b0000, 0, 0, 1, 1);

        // async reset pulse mid-ramp, between clock edges
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0001, 0, 1, 0, 1);
        vec(1, 0, 4'b0011, 0, 1, 0, 1);
        @(negedge CLK);
        #1 RN = 1'b0; REQ = 1'b0;
        #1 compare("async_rst", dut_word(), exp_word('{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}));
        #1 RN = 1'b1;
        sb.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
        rep(3, 0, 0, 4'b0000, 0, 0, 0, 1);

        repeat (3) @(posedge CLK);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
